// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and score width for the sprite game controller.
package game_pkg;
   typedef enum logic [2:0] {S_START, S_AIM, S_SHOOT, S_WON, S_LOST} game_state_t;
   localparam int SCORE_W = 8;
endpackage

// File: rtl/game_sequencer_strobe_gen.sv
// strobe_gen: free-running wrap counter emitting one strobe every 2^width cycles.
module strobe_gen #(
   parameter int width = 20
) (
   input  logic clk,
   input  logic reset_n,
   output logic strobe
);
   logic [width-1:0] cnt;
   always_ff @(posedge clk)
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt + 1'b1;
   assign strobe = &cnt;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round sequencer (start, aim, shoot, won/lost) for the sprite game.
// Define GAME_SEQUENCER_SCORE_EN to build the saturating win counter on score.
module game_sequencer
   import game_pkg::*;
#(
   parameter int clk_mhz                           = 50,
   parameter int strobe_to_update_xy_counter_width = 20,
   parameter int end_strobes                       = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               launch,
   input  logic               collision,
   input  logic               target_out_of_screen,
   input  logic               torpedo_out_of_screen,
   output logic               target_write_xy,
   output logic               torpedo_write_xy,
   output logic               target_write_dxy,
   output logic               torpedo_write_dxy,
   output logic               sprite_enable_update,
   output logic               game_won,
   output logic               game_lost,
   output logic [SCORE_W-1:0] score
);
   localparam int END_W = $clog2(end_strobes + 1);
   if (clk_mhz < 1 || strobe_to_update_xy_counter_width < 1 || end_strobes < 1)
      $error("game_sequencer: parameters must all be >= 1");
   game_state_t      state, state_n;
   logic [END_W-1:0] end_cnt, end_n, end_inc;
   logic             strobe, launch_d, launch_rise;
   logic             txy_n, pxy_n, tdxy_n, pdxy_n;
   strobe_gen #(.width(strobe_to_update_xy_counter_width)) u_strobe (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (strobe)
   );
   assign launch_rise = launch & ~launch_d;
   assign end_inc     = end_cnt + 1'b1;
   always_comb begin
      state_n = state;
      end_n   = end_cnt;
      txy_n   = 1'b0;
      pxy_n   = 1'b0;
      tdxy_n  = 1'b0;
      pdxy_n  = 1'b0;
      case (state)
         S_START: begin
            state_n = S_AIM;
            txy_n   = 1'b1;
            pxy_n   = 1'b1;
            tdxy_n  = 1'b1;
         end
         S_AIM:
            if (target_out_of_screen) begin
               state_n = S_LOST;
               end_n   = '0;
            end else if (launch_rise) begin
               state_n = S_SHOOT;
               pdxy_n  = 1'b1;
            end
         S_SHOOT:
            if (collision) begin
               state_n = S_WON;
               end_n   = '0;
            end else if (target_out_of_screen || torpedo_out_of_screen) begin
               state_n = S_LOST;
               end_n   = '0;
            end
         default:
            if (strobe) begin
               end_n   = end_inc;
               state_n = (end_inc == END_W'(end_strobes)) ? S_START : state;
            end
      endcase
   end
   always_ff @(posedge clk)
      if (!reset_n) begin
         state             <= S_START;
         end_cnt           <= '0;
         launch_d          <= 1'b1;
         target_write_xy   <= 1'b0;
         torpedo_write_xy  <= 1'b0;
         target_write_dxy  <= 1'b0;
         torpedo_write_dxy <= 1'b0;
      end else begin
         state             <= state_n;
         end_cnt           <= end_n;
         launch_d          <= launch;
         target_write_xy   <= txy_n;
         torpedo_write_xy  <= pxy_n;
         target_write_dxy  <= tdxy_n;
         torpedo_write_dxy <= pdxy_n;
      end
   assign sprite_enable_update = strobe & (state == S_AIM || state == S_SHOOT);
   assign game_won             = state == S_WON;
   assign game_lost            = state == S_LOST;
`ifdef GAME_SEQUENCER_SCORE_EN
   logic [SCORE_W-1:0] score_q;
   always_ff @(posedge clk)
      if (!reset_n)
         score_q <= '0;
      else if (state == S_SHOOT && collision && !(&score_q))
         score_q <= score_q + 1'b1;
   assign score = score_q;
`else
   assign score = '0;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of game_sequencer with W = 1 and end_strobes = 4.
module tb_game_sequencer;
   logic       clk = 1'b0, reset_n = 1'b0;
   logic       launch = 1'b0, collision = 1'b0, tos = 1'b0, pos = 1'b0;
   logic       target_write_xy, torpedo_write_xy, target_write_dxy, torpedo_write_dxy;
   logic       sprite_enable_update, game_won, game_lost;
   logic [7:0] score;
   logic       mcnt = 1'b0;
   int         n_checks = 0, n_fail = 0, n;
`ifdef GAME_SEQUENCER_SCORE_EN
   localparam int SCORE_ONE = 1;
`else
   localparam int SCORE_ONE = 0;
`endif
   game_sequencer #(
      .clk_mhz                           (50),
      .strobe_to_update_xy_counter_width (1),
      .end_strobes                       (4)
   ) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .launch                (launch),
      .collision             (collision),
      .target_out_of_screen  (tos),
      .torpedo_out_of_screen (pos),
      .target_write_xy       (target_write_xy),
      .torpedo_write_xy      (torpedo_write_xy),
      .target_write_dxy      (target_write_dxy),
      .torpedo_write_dxy     (torpedo_write_dxy),
      .sprite_enable_update  (sprite_enable_update),
      .game_won              (game_won),
      .game_lost             (game_lost),
      .score                 (score)
   );
   always #5 clk = ~clk;
   always @(posedge clk) mcnt <= reset_n ? ~mcnt : 1'b0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check_pulses(input string tag, input logic [3:0] exp);
      check(tag, {target_write_xy, torpedo_write_xy, target_write_dxy, torpedo_write_dxy}, exp);
   endtask
   task automatic check_idle(input string tag);
      check(tag, {target_write_xy, torpedo_write_xy, target_write_dxy, torpedo_write_dxy,
                  sprite_enable_update, game_won, game_lost, score}, 0);
   endtask
   task automatic wait_end(input string tag, output int cycles);
      cycles = 0;
      while ((game_won || game_lost) && cycles < 40) begin
         step();
         cycles++;
      end
      check({tag, "_timeout"}, 32'(cycles < 40), 1);
   endtask
   task automatic win_round();
      launch = 1'b0; step();
      launch = 1'b1; step();
      launch = 1'b0; collision = 1'b1; step();
      collision = 1'b0;
      wait_end("win_loop", n);
      step();
   endtask
   initial begin
      repeat (3) step();
      check_idle("reset_outputs");
      reset_n = 1'b1; step();
      check_pulses("release_pulses", 4'b1110);
      check("release_en", sprite_enable_update, 1);
      step();
      check_pulses("release_pulses_end", 4'b0000);
      check("en_toggle0", sprite_enable_update, 0);
      step();
      check("en_toggle1", sprite_enable_update, 1);
      launch = 1'b1; step();
      check_pulses("launch_dxy", 4'b0001);
      launch = 1'b0; step();
      check_pulses("launch_dxy_end", 4'b0000);
      check("shoot_not_won", game_won, 0);
      collision = 1'b1; step();
      collision = 1'b0;
      check("won", game_won, 1);
      check("won_en", sprite_enable_update, 0);
      check("won_score", score, SCORE_ONE);
      begin
         int exp_len = mcnt ? 7 : 8;
         wait_end("won_end", n);
         check("won_len", n, exp_len);
      end
      check_pulses("start_no_pulse", 4'b0000);
      step();
      check_pulses("round2_pulses", 4'b1110);
      step();
      tos = 1'b1; step();
      tos = 1'b0;
      check("lost", game_lost, 1);
      check("lost_not_won", game_won, 0);
      for (int i = 0; i < 4; i++) begin
         launch = ~launch; step();
         check("lost_no_dxy", torpedo_write_dxy, 0);
      end
      launch = 1'b0;
      wait_end("lost_end", n);
      step();
      check_pulses("round3_pulses", 4'b1110);
      step();
      launch = 1'b1; step();
      check_pulses("launch3_dxy", 4'b0001);
      launch = 1'b0; step();
      launch = 1'b1; step();
      check("shoot_relaunch", torpedo_write_dxy, 0);
      check("shoot_stays", {game_won, game_lost}, 2'b00);
      launch = 1'b0; collision = 1'b1; pos = 1'b1; step();
      collision = 1'b0; pos = 1'b0;
      check("simul_won", game_won, 1);
      check("simul_lost", game_lost, 0);
      wait_end("simul_end", n);
      step();
      launch = 1'b1; reset_n = 1'b0; step(); step();
      check_idle("held_reset");
      reset_n = 1'b1; step();
      check_pulses("held_release", 4'b1110);
      repeat (3) begin
         step();
         check("held_no_launch", torpedo_write_dxy, 0);
      end
      launch = 1'b0; step();
      launch = 1'b1; step();
      check("held_relaunch", torpedo_write_dxy, 1);
      launch = 1'b0; reset_n = 1'b0; step();
      check_idle("midround_reset");
      reset_n = 1'b1; step();
      check_pulses("midround_pulses", 4'b1110);
      check("midround_en", sprite_enable_update, 1);
      step();
      check("midround_en0", sprite_enable_update, 0);
`ifdef GAME_SEQUENCER_SCORE_EN
      for (int i = 0; i < 260; i++) win_round();
      check("score_sat", score, 255);
`else
      win_round();
      check("score_tied", score, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
